// File: rtl/track_position_ctrl_if.sv
// ---------------------------------------------------------------------------
// track_position_ctrl_if
// Command channel between the main controller and the track position
// sequencer. A command transfers on a cycle where cmd_valid and cmd_ready
// are both high.
//
// Signals
//   cmd_valid  controller -> sequencer  command present
//   cmd_ready  sequencer -> controller  sequencer can accept a command
//   cmd_home   controller -> sequencer  1 = home command (cmd_pos ignored)
//   cmd_pos    controller -> sequencer  target position for a move command
//
// Modports
//   master  the controller side (drives the command)
//   slave   the sequencer side (drives cmd_ready)
// ---------------------------------------------------------------------------
interface track_position_ctrl_if #(
    parameter int POS_W = 12
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_home;
    logic [POS_W-1:0] cmd_pos;

    modport master (
        output cmd_valid,
        output cmd_home,
        output cmd_pos,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_home,
        input  cmd_pos,
        output cmd_ready
    );
endinterface

// File: rtl/track_position_ctrl.sv
// ---------------------------------------------------------------------------
// track_position_ctrl
// Position sequencer for the track stepper. Takes move/home commands over a
// valid/ready channel, drives move_o/back_o into track_driver, counts steps
// to reach a target, keeps the absolute position, homes against a limit
// switch and reports completion, rejections and faults.
//
// Ports
//   clk       in   system clock
//   rst       in   asynchronous reset, active-high
//   cmd       slave modport of track_position_ctrl_if (valid/ready/home/pos)
//   abort     in   stop current motion
//   home_sw   in   home limit switch, 1 = at home (already synchronized)
//   move_o    out  to track_driver move_i
//   back_o    out  to track_driver back_i, 1 = toward home
//   busy_o    out  sequencer not idle
//   done_o    out  one-cycle pulse: command completed or rejected
//   err_o     out  one-cycle pulse with done_o: rejected, aborted, timed out
//   fault_o   out  sticky homing timeout, cleared by an accepted home command
//   homed_o   out  position reference valid
//   pos_o     out  current position in steps
// ---------------------------------------------------------------------------
module track_position_ctrl #(
    parameter int STEP_CYCLES   = 500000,
    parameter int SETTLE_CYCLES = 50000,
    parameter int POS_W         = 12,
    parameter int MAX_POS       = 2000,
    parameter int HOME_TIMEOUT  = 4095
) (
    input  logic                  clk,
    input  logic                  rst,
    track_position_ctrl_if.slave  cmd,
    input  logic                  abort,
    input  logic                  home_sw,
    output logic                  move_o,
    output logic                  back_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  fault_o,
    output logic                  homed_o,
    output logic [POS_W-1:0]      pos_o
);

    localparam int CNT_W    = (STEP_CYCLES > 1)   ? $clog2(STEP_CYCLES)   : 1;
    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int STEPS_W  = $clog2(HOME_TIMEOUT + 1);

    localparam logic [CNT_W-1:0]    STEP_LAST   = CNT_W'(STEP_CYCLES - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [STEPS_W-1:0]  HOME_LAST   = STEPS_W'(HOME_TIMEOUT);
    localparam logic [POS_W-1:0]    MAX_POS_V   = POS_W'(MAX_POS);

    typedef enum logic [1:0] {
        IDLE,
        HOMING,
        MOVE,
        SETTLE
    } state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    step_cnt, step_cnt_n;
    logic [STEPS_W-1:0]  home_steps, home_steps_n;
    logic [SETTLE_W-1:0] settle_cnt, settle_cnt_n;
    logic [POS_W-1:0]    pos, pos_n;
    logic [POS_W-1:0]    target, target_n;
    logic                err_flag, err_flag_n;
    logic                ready, ready_n;
    logic                move, move_n;
    logic                back, back_n;
    logic                busy, busy_n;
    logic                done, done_n;
    logic                err, err_n;
    logic                fault, fault_n;
    logic                homed, homed_n;
    logic                tick;

    // Every output is a flop; this block only registers the next values
    // worked out by the combinational block below.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            step_cnt   <= '0;
            home_steps <= '0;
            settle_cnt <= '0;
            pos        <= '0;
            target     <= '0;
            err_flag   <= 1'b0;
            ready      <= 1'b1;
            move       <= 1'b0;
            back       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            fault      <= 1'b0;
            homed      <= 1'b0;
        end else begin
            state      <= state_n;
            step_cnt   <= step_cnt_n;
            home_steps <= home_steps_n;
            settle_cnt <= settle_cnt_n;
            pos        <= pos_n;
            target     <= target_n;
            err_flag   <= err_flag_n;
            ready      <= ready_n;
            move       <= move_n;
            back       <= back_n;
            busy       <= busy_n;
            done       <= done_n;
            err        <= err_n;
            fault      <= fault_n;
            homed      <= homed_n;
        end
    end

    // Next-state and next-output logic. A tick in the same cycle as abort is
    // applied first, so a step that lands on that edge is never lost. The
    // step counter restarts whenever HOMING or MOVE is entered.
    always_comb begin
        state_n      = state;
        step_cnt_n   = step_cnt;
        home_steps_n = home_steps;
        settle_cnt_n = settle_cnt;
        pos_n        = pos;
        target_n     = target;
        err_flag_n   = err_flag;
        move_n       = move;
        back_n       = back;
        done_n       = 1'b0;
        err_n        = 1'b0;
        fault_n      = fault;
        homed_n      = homed;
        tick         = (step_cnt == STEP_LAST);

        case (state)
            IDLE: begin
                if (cmd.cmd_valid && ready) begin
                    if (cmd.cmd_home) begin
                        fault_n      = 1'b0;
                        homed_n      = 1'b0;
                        move_n       = 1'b1;
                        back_n       = 1'b1;
                        step_cnt_n   = '0;
                        home_steps_n = '0;
                        err_flag_n   = 1'b0;
                        state_n      = HOMING;
                    end else if (!homed || (cmd.cmd_pos > MAX_POS_V)) begin
                        done_n = 1'b1;
                        err_n  = 1'b1;
                    end else if (cmd.cmd_pos == pos) begin
                        settle_cnt_n = '0;
                        err_flag_n   = 1'b0;
                        state_n      = SETTLE;
                    end else begin
                        target_n   = cmd.cmd_pos;
                        back_n     = (cmd.cmd_pos < pos);
                        move_n     = 1'b1;
                        step_cnt_n = '0;
                        err_flag_n = 1'b0;
                        state_n    = MOVE;
                    end
                end
            end

            HOMING: begin
                step_cnt_n = tick ? '0 : step_cnt + 1'b1;
                if (home_sw) begin
                    // Switch closed: this is the new origin, even if no
                    // step was taken at all.
                    pos_n        = '0;
                    homed_n      = 1'b1;
                    move_n       = 1'b0;
                    settle_cnt_n = '0;
                    state_n      = SETTLE;
                end else begin
                    if (tick) begin
                        home_steps_n = home_steps + 1'b1;
                    end
                    if (tick && (home_steps_n == HOME_LAST)) begin
                        // Timed out: report straight away, no settle phase.
                        move_n  = 1'b0;
                        fault_n = 1'b1;
                        done_n  = 1'b1;
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end else if (abort) begin
                        move_n       = 1'b0;
                        err_flag_n   = 1'b1;
                        settle_cnt_n = '0;
                        state_n      = SETTLE;
                    end
                end
            end

            MOVE: begin
                step_cnt_n = tick ? '0 : step_cnt + 1'b1;
                if (tick) begin
                    pos_n = back ? (pos - 1'b1) : (pos + 1'b1);
                end
                if (tick && (pos_n == target)) begin
                    move_n       = 1'b0;
                    settle_cnt_n = '0;
                    state_n      = SETTLE;
                end else if (abort) begin
                    move_n       = 1'b0;
                    err_flag_n   = 1'b1;
                    settle_cnt_n = '0;
                    state_n      = SETTLE;
                end
            end

            SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    done_n  = 1'b1;
                    err_n   = err_flag;
                    state_n = IDLE;
                end else begin
                    settle_cnt_n = settle_cnt + 1'b1;
                end
            end

            default: begin
                move_n  = 1'b0;
                state_n = IDLE;
            end
        endcase

        // The done cycle itself is not ready; ready comes back one cycle later.
        ready_n = (state_n == IDLE) && !done_n;
        busy_n  = (state_n != IDLE);
    end

    assign cmd.cmd_ready = ready;
    assign move_o        = move;
    assign back_o        = back;
    assign busy_o        = busy;
    assign done_o        = done;
    assign err_o         = err;
    assign fault_o       = fault;
    assign homed_o       = homed;
    assign pos_o         = pos;

endmodule
